// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, multiplier op encoding and multiplier FSM states
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mul_state_e;
endpackage

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: iterative shift-add 32x32 multiplier feeding the ALU result mux
module alu_seq_multiplier
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [1:0]      mul_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  mul_state_e        state, state_nxt;
  logic [1:0]        op;
  logic [XLEN-1:0]   mcand, mplier, mag_a, mag_b;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN:0]     sum;
  logic [4:0]        cnt;
  logic              neg, sgn_a, sgn_b;
  always_comb begin
    sgn_a = (mul_op_i == MULH || mul_op_i == MULHSU) && op_a_i[XLEN-1];
    sgn_b = (mul_op_i == MULH) && op_b_i[XLEN-1];
    mag_a = sgn_a ? -op_a_i : op_a_i;
    mag_b = sgn_b ? -op_b_i : op_b_i;
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod  = neg ? -acc : acc;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start_i ? CALC : IDLE) :
                state == CALC ? (cnt == 5'd31 ? FIX : CALC) : IDLE;
  always_comb busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      op       <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          op     <= mul_op_i;
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= sgn_a ^ sgn_b;
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          acc    <= {sum, acc[XLEN-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        FIX: begin
          result_o <= op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// tb_alu_seq_multiplier: directed self-checking bench for the sequential multiplier
module tb_alu_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, valid;
  logic [31:0] result;
  int          checks = 0, errors = 0;
  alu_seq_multiplier dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mul_op_i(op),
    .op_a_i(a), .op_b_i(b), .busy_o(busy), .valid_o(valid), .result_o(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 999;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp);
    int c;
    go(o, x, y);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_valid(c);
    chk({tag, "_lat"}, c, 32'd33);
    chk({tag, "_busy_at_valid"}, {31'b0, busy}, 32'd0);
    chk({tag, "_res"}, result, exp);
  endtask
  initial begin
    int n, t1, t2, r1, r2, held_bad;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42);
    go(2'b00, 32'd100, 32'd100);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15);
    run("mulhu_7x6", 2'b11, 32'd7, 32'd6, 32'd0);
    run("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulh_m1x1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run("mul_m1x1", 2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    go(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0; t1 = 0; r1 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 5 || i == 20) begin
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (valid) begin
        n++;
        t1 = i;
        r1 = result;
      end
    end
    chk("ign_pulses", n, 32'd1);
    chk("ign_lat", t1, 32'd33);
    chk("ign_res", r1, 32'hFFFF_FFFE);
    @(negedge clk);
    op = 2'b00; a = 32'd0; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 a = 32'd2;
    n = 0; t1 = 0; t2 = 0; r1 = -1; r2 = -1; held_bad = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n++;
        if (n == 1) begin
          t1 = i;
          r1 = result;
        end else begin
          t2 = i;
          r2 = result;
          start = 1'b0;
          break;
        end
      end else if (n == 1 && result !== 32'd0) held_bad++;
    end
    start = 1'b0;
    chk("b2b_t1", t1, 32'd33);
    chk("b2b_t2", t2, 32'd67);
    chk("b2b_r1", r1, 32'd0);
    chk("b2b_r2", r2, 32'd18);
    chk("b2b_hold", held_bad, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("b2b_idle", {31'b0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
